// File: rtl/ddr_definitions.sv
// Shared definitions for the arrow sequencer: FSM encoding, arrow codes and default sizes.
package ddr_definitions;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_OVER = 2'd3
    } seq_state_t;

    localparam int DEF_QUEUE_DEPTH = 4;
    localparam int DEF_MAX_MISSES  = 8;
    localparam int DEF_ARROW_W     = 4;

    localparam logic [DEF_ARROW_W-1:0] ARROW_EMPTY  = 4'd0;
    localparam logic [DEF_ARROW_W-1:0] ARROW_LEFT   = 4'd10;
    localparam logic [DEF_ARROW_W-1:0] ARROW_DOWN   = 4'd11;
    localparam logic [DEF_ARROW_W-1:0] ARROW_UP     = 4'd12;
    localparam logic [DEF_ARROW_W-1:0] ARROW_RIGHT  = 4'd13;
    localparam logic [DEF_ARROW_W-1:0] ARROW_CENTER = 4'd14;

endpackage

// File: rtl/arrow_queue.sv
// Shift register of upcoming arrows; slot0 (head) sits in the low bits, new arrows enter at the tail.
module arrow_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift,
    input  logic [WIDTH-1:0]       load_data,
    output logic [DEPTH*WIDTH-1:0] slots
);

    logic [DEPTH*WIDTH-1:0] slots_reg;
    logic [DEPTH*WIDTH-1:0] slots_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            if (gi == DEPTH - 1) begin : g_tail
                assign slots_next[gi*WIDTH +: WIDTH] = load_data;
            end else begin : g_body
                assign slots_next[gi*WIDTH +: WIDTH] = slots_reg[(gi+1)*WIDTH +: WIDTH];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slots_reg <= '0;
        end else if (shift) begin
            slots_reg <= slots_next;
        end
    end

    assign slots = slots_reg;

endmodule

// File: rtl/arrow_sequencer.sv
// Rhythm-game controller: fills the arrow queue, judges presses against the head, counts hits and misses.
module arrow_sequencer
    import ddr_definitions::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int MAX_MISSES = DEF_MAX_MISSES,
    parameter int ARROW_W = DEF_ARROW_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         beat_tick,
    input  logic                         btn_valid,
    input  logic [ARROW_W-1:0]           btn_arrow,
    input  logic [ARROW_W-1:0]           rand_arrow,
    output logic                         rand_advance,
    output logic [QUEUE_DEPTH*ARROW_W-1:0] arrow_q,
    output logic                         head_hit,
    output logic                         hit,
    output logic                         wrong,
    output logic                         miss,
    output logic [15:0]                  score,
    output logic [3:0]                   miss_count,
    output logic [1:0]                   fsm_state
);

    localparam int FILL_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(QUEUE_DEPTH - 1);
    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

    seq_state_t        state_reg, state_next;
    logic [FILL_W-1:0] fill_cnt_reg, fill_cnt_next;
    logic [15:0]       score_reg, score_next;
    logic [3:0]        miss_cnt_reg, miss_cnt_next;
    logic              head_hit_reg, head_hit_next;
    logic              hit_reg, hit_next;
    logic              wrong_reg, wrong_next;
    logic              miss_reg, miss_next;
    logic              q_clear, q_shift, press_match;
    logic [ARROW_W-1:0] head;

    arrow_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ARROW_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (q_clear),
        .shift     (q_shift),
        .load_data (rand_arrow),
        .slots     (arrow_q)
    );

    assign head = arrow_q[ARROW_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            fill_cnt_reg <= '0;
            score_reg    <= '0;
            miss_cnt_reg <= '0;
            head_hit_reg <= 1'b0;
            hit_reg      <= 1'b0;
            wrong_reg    <= 1'b0;
            miss_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= fill_cnt_next;
            score_reg    <= score_next;
            miss_cnt_reg <= miss_cnt_next;
            head_hit_reg <= head_hit_next;
            hit_reg      <= hit_next;
            wrong_reg    <= wrong_next;
            miss_reg     <= miss_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fill_cnt_next = fill_cnt_reg;
        score_next    = score_reg;
        miss_cnt_next = miss_cnt_reg;
        head_hit_next = head_hit_reg;
        hit_next      = 1'b0;
        wrong_next    = 1'b0;
        miss_next     = 1'b0;
        q_clear       = 1'b0;
        q_shift       = 1'b0;
        rand_advance  = 1'b0;
        // The press is judged against the head as it stands before any same-cycle shift.
        press_match   = btn_valid && !head_hit_reg && (btn_arrow == head);

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_FILL;
                    fill_cnt_next = '0;
                    score_next    = '0;
                    miss_cnt_next = '0;
                    head_hit_next = 1'b0;
                    q_clear       = 1'b1;
                end
            end
            ST_FILL: begin
                rand_advance  = 1'b1;
                q_shift       = 1'b1;
                fill_cnt_next = fill_cnt_reg + FILL_W'(1);
                if (fill_cnt_reg == FILL_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (btn_valid) begin
                    if (press_match) begin
                        hit_next      = 1'b1;
                        head_hit_next = 1'b1;
                        if (score_reg != 16'hFFFF) begin
                            score_next = score_reg + 16'd1;
                        end
                    end else begin
                        wrong_next = 1'b1;
                    end
                end
                if (beat_tick) begin
                    rand_advance  = 1'b1;
                    q_shift       = 1'b1;
                    head_hit_next = 1'b0;
                    if (!head_hit_reg && !press_match && (miss_cnt_reg < MISS_LIMIT)) begin
                        miss_next     = 1'b1;
                        miss_cnt_next = miss_cnt_reg + 4'd1;
                        if (miss_cnt_next == MISS_LIMIT) begin
                            state_next = ST_OVER;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_next    = ST_IDLE;
                    score_next    = '0;
                    miss_cnt_next = '0;
                    head_hit_next = 1'b0;
                    q_clear       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign head_hit   = head_hit_reg;
    assign hit        = hit_reg;
    assign wrong      = wrong_reg;
    assign miss       = miss_reg;
    assign score      = score_reg;
    assign miss_count = miss_cnt_reg;
    assign fsm_state  = state_reg;

endmodule

// File: doc/arrow_sequencer.md
ARROW_SEQUENCER -- requirements
Module: arrow_sequencer

Interface
REQ-001 SHALL have parameters, one per line: QUEUE_DEPTH, default 4, number of upcoming-arrow slots; MAX_MISSES, default 8, misses that end the game; ARROW_W, default 4, arrow code width.
REQ-002 SHALL have ports, one per line, with the clock and reset listed first.
- clk  in  1  system clock; the single clock for the block.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse that begins a game.
- beat_tick  in  1  one-cycle pulse marking a metronome beat.
- btn_valid  in  1  one-cycle pulse marking a player press.
- btn_arrow  in  ARROW_W  arrow code of the press.
- rand_arrow  in  ARROW_W  current generator arrow, valid codes 10..14.
- rand_advance  out  1  steps the random generator at the end of this cycle.
- arrow_q  out  QUEUE_DEPTH*ARROW_W  packed slots; slot0 (the head) is in bits [ARROW_W-1:0]; code 0 means an empty slot.
- head_hit  out  1  the head slot has already been hit.
- hit, wrong, miss  out  1 each  one-cycle event pulses.
- score  out  16  hit count, saturating.
- miss_count  out  4  miss count.
- fsm_state  out  2  encoding: IDLE=0, FILL=1, RUN=2, OVER=3.

Function
REQ-003 FSM transitions SHALL be:
- IDLE -> FILL on start.
- FILL -> RUN after QUEUE_DEPTH cycles.
- RUN -> OVER in the cycle miss_count reaches MAX_MISSES.
- OVER -> IDLE on start.
- All other inputs SHALL be ignored in IDLE and OVER.
REQ-004 Leaving IDLE or OVER on start SHALL clear score, miss_count, arrow_q and head_hit in the same edge.
REQ-005 In FILL, rand_advance SHALL be 1 every cycle. Each cycle SHALL shift the queue down one slot and capture rand_arrow into slot QUEUE_DEPTH-1. After 4 cycles all slots SHALL be non-zero.
REQ-006 The controller SHALL sample rand_arrow in the same cycle rand_advance is high; the generator holds its value while rand_advance is low.
REQ-007 On beat_tick in RUN:
- The queue SHALL shift (slot i <= slot i+1).
- rand_arrow SHALL load into the tail slot.
- rand_advance SHALL be 1 in that cycle.
- head_hit SHALL clear.
REQ-008 On beat_tick in RUN with the outgoing head not hit:
- miss SHALL pulse.
- miss_count SHALL increment.
REQ-009 On btn_valid in RUN with btn_arrow equal to slot0 and head_hit=0:
- hit SHALL pulse.
- score SHALL increment, saturating at 16'hFFFF.
- head_hit SHALL set.
REQ-010 On btn_valid in RUN with a mismatch, or with head_hit=1:
- wrong SHALL pulse.
- score and the queue SHALL be unchanged.
REQ-011 When btn_valid and beat_tick occur in the same cycle, the press SHALL be judged against the pre-shift slot0 first. A matching press SHALL suppress that beat's miss; the shift then proceeds.
REQ-012 Event pulses (hit, wrong, miss) SHALL be registered: asserted for exactly one cycle, on the cycle after the triggering input edge.
REQ-013 rand_advance SHALL be combinational from the FSM state and beat_tick; it SHALL be 0 in IDLE and OVER.
REQ-014 beat_tick during FILL SHALL be ignored, with no miss and no extra advance.
REQ-015 miss_count SHALL never exceed MAX_MISSES.
REQ-016 Outputs SHALL hold in OVER.

Reset
REQ-017 rst SHALL take priority over every other input.
REQ-018 On rst the block SHALL enter IDLE, zero all slots, score, miss_count and head_hit, and drive all pulse outputs to 0.
REQ-019 rst asserted mid-FILL or mid-RUN SHALL abort the game with no miss and no hit pulse emitted.

Structure
REQ-020 The shared definitions package (ddr_definitions) SHALL hold:
- the FSM state encodings;
- the arrow codes 10..14 and the empty code 0;
- QUEUE_DEPTH, MAX_MISSES and ARROW_W defaults.
REQ-021 The shift-register slots SHALL be a sub-module, arrow_queue, with ports: shift, load data, clear, and packed output.
REQ-022 The FSM, judging and counters SHALL live in arrow_sequencer.

Verification
REQ-023 rst, then start with rand_arrow stepping 10,11,12,13 -> fsm_state=RUN after 4 FILL cycles, arrow_q slot0..3 = 10,11,12,13, rand_advance high exactly 4 cycles.
REQ-024 In RUN, head=10, btn_arrow=10 -> hit one cycle, score=1, head_hit=1; a repeat press of 10 -> wrong, score still 1.
REQ-025 head=12, beat_tick with no press, rand_arrow=14 -> miss pulse, miss_count=1, tail=14, slot0=former slot1.
REQ-026 btn_valid (matching head) and beat_tick in the same cycle -> hit, no miss, queue shifted, score+1.
REQ-027 Eight consecutive unhit beats -> miss_count=8, fsm_state=OVER; further beats and presses produce no pulses; start -> IDLE with counters at 0.
REQ-028 rst asserted during RUN with score=5 -> next cycle IDLE, score=0, arrow_q=0, no pulses.
